// File: rtl/lif_step_scheduler_if.sv
// Bundles the state-RAM port and the LIF-core request/result channel that
// connect the step scheduler to the rest of the neuron array.
interface lif_step_scheduler_if #(
  parameter int ADDR_W = 4,
  parameter int VW     = 8,
  parameter int TREF_W = 4
);
  // State RAM port; read data is valid one cycle after mem_rd_en.
  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_rd_en;
  logic [VW+TREF_W-1:0] mem_rd_data;
  logic                 mem_wr_en;
  logic [VW+TREF_W-1:0] mem_wr_data;

  // LIF core request handshake and result strobe.
  logic                 core_valid;
  logic                 core_ready;
  logic [ADDR_W-1:0]    core_neuron;
  logic [VW-1:0]        core_potential;
  logic                 core_res_valid;
  logic [VW-1:0]        core_res_potential;
  logic                 core_res_spike;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
    input  mem_rd_data,
    output core_valid, core_neuron, core_potential,
    input  core_ready, core_res_valid, core_res_potential, core_res_spike
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
    output mem_rd_data,
    input  core_valid, core_neuron, core_potential,
    output core_ready, core_res_valid, core_res_potential, core_res_spike
  );
endinterface

// File: rtl/lif_step_scheduler.sv
// Walks every logical neuron once per timestep, sharing one LIF core:
// read state word, either count down the refractory period locally or send
// the potential through the core, write the new state back, and publish the
// collected spike vector when the walk finishes.
module lif_step_scheduler #(
  parameter int NUM_NEURONS = 16,
  parameter int ADDR_W      = 4,
  parameter int VW          = 8,
  parameter int TREF_W      = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   step_start,
  input  logic [TREF_W-1:0]      tref,
  output logic                   step_busy,
  output logic                   step_done,
  output logic [NUM_NEURONS-1:0] spike_vec,
  lif_step_scheduler_if.master   bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT_RD,
    ISSUE,
    WAIT_RES,
    WRITE,
    DONE
  } state_t;

  state_t                 state;
  logic [ADDR_W-1:0]      idx;
  logic [NUM_NEURONS-1:0] shadow;

  logic [VW-1:0]          rd_pot;
  logic [TREF_W-1:0]      rd_ref;

  assign rd_pot = bus.mem_rd_data[VW+TREF_W-1:TREF_W];
  assign rd_ref = bus.mem_rd_data[TREF_W-1:0];

  // Scheduler FSM; every output is registered and set on entry to the state
  // that owns it, so strobes line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      idx                <= '0;
      shadow             <= '0;
      spike_vec          <= '0;
      step_busy          <= 1'b0;
      step_done          <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_rd_en      <= 1'b0;
      bus.mem_wr_en      <= 1'b0;
      bus.mem_wr_data    <= '0;
      bus.core_valid     <= 1'b0;
      bus.core_neuron    <= '0;
      bus.core_potential <= '0;
    end else begin
      bus.mem_rd_en <= 1'b0;
      bus.mem_wr_en <= 1'b0;
      bus.mem_addr  <= '0;
      step_done     <= 1'b0;

      case (state)
        IDLE: begin
          if (step_start) begin
            state         <= READ;
            idx           <= '0;
            shadow        <= '0;
            step_busy     <= 1'b1;
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= '0;
          end
        end

        READ: begin
          state <= WAIT_RD;
        end

        WAIT_RD: begin
          if (rd_ref != '0) begin
            state           <= WRITE;
            bus.mem_wr_en   <= 1'b1;
            bus.mem_addr    <= idx;
            bus.mem_wr_data <= {{VW{1'b0}}, rd_ref - TREF_W'(1)};
          end else begin
            state              <= ISSUE;
            bus.core_valid     <= 1'b1;
            bus.core_neuron    <= idx;
            bus.core_potential <= rd_pot;
          end
        end

        ISSUE: begin
          if (bus.core_ready) begin
            state              <= WAIT_RES;
            bus.core_valid     <= 1'b0;
            bus.core_neuron    <= '0;
            bus.core_potential <= '0;
          end
        end

        WAIT_RES: begin
          if (bus.core_res_valid) begin
            state         <= WRITE;
            bus.mem_wr_en <= 1'b1;
            bus.mem_addr  <= idx;
            if (bus.core_res_spike) begin
              bus.mem_wr_data <= {{VW{1'b0}}, tref};
              shadow[idx]     <= 1'b1;
            end else begin
              bus.mem_wr_data <= {bus.core_res_potential, {TREF_W{1'b0}}};
            end
          end
        end

        WRITE: begin
          if (idx == LAST_IDX) begin
            state     <= DONE;
            step_done <= 1'b1;
            spike_vec <= shadow;
          end else begin
            state         <= READ;
            idx           <= idx + ADDR_W'(1);
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= idx + ADDR_W'(1);
          end
        end

        DONE: begin
          state     <= IDLE;
          step_busy <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
